// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: shares the CCI-P c0 read-request channel between N_REQ
// read engines. Round-robin grant, c0TxAlmFull back-pressure, per-requester
// outstanding cap, requester ID carried in mdata[15:16-ID_W] and used to route
// read responses back. Optional statistics via `define CCIP_RD_ARB_STATS_EN.

// Per-requester outstanding counter, response strobe and error detect.
module ccip_c0_rd_arbiter_lane #(
  parameter int MAX_OUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic afu_clk,
  input  logic afu_rst_n,
  input  logic i_inc,      // request granted this cycle
  input  logic i_dec,      // response tagged for this lane this cycle
  output logic o_ok,       // below the outstanding cap
  output logic o_busy,
  output logic o_rsp,
  output logic o_err       // response with nothing outstanding
`ifdef CCIP_RD_ARB_STATS_EN
  , output logic [31:0] o_gnt_cnt
`endif
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             r_rsp;
  logic             w_dec_ok;

  assign w_dec_ok = i_dec & (r_cnt != '0);
  assign o_err    = i_dec & (r_cnt == '0);
  assign o_ok     = (r_cnt < CNT_W'(MAX_OUT));
  assign o_busy   = r_busy;
  assign o_rsp    = r_rsp;

  // Next count: grant and good response in the same cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !w_dec_ok)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!i_inc && w_dec_ok) w_cnt_nxt = r_cnt - 1'b1;
  end

  // Counter with busy flag registered alongside it.
  always_ff @(posedge afu_clk or negedge afu_rst_n) begin
    if (!afu_rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_rsp  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_rsp  <= w_dec_ok;
    end
  end

`ifdef CCIP_RD_ARB_STATS_EN
  logic [31:0] r_gnt_cnt;
  assign o_gnt_cnt = r_gnt_cnt;

  // Free-running grant counter, wraps at 2**32.
  always_ff @(posedge afu_clk or negedge afu_rst_n) begin
    if (!afu_rst_n)  r_gnt_cnt <= '0;
    else if (i_inc)  r_gnt_cnt <= r_gnt_cnt + 32'd1;
  end
`endif
endmodule

module ccip_c0_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int ID_W    = 3,
  parameter int MAX_OUT = 64,
  localparam int UMD_W  = 16 - ID_W
) (
  input  logic                    afu_clk,
  input  logic                    afu_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*UMD_W-1:0]  req_mdata,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    c0tx_almfull,
  output logic                    c0tx_valid,
  output logic [ADDR_W-1:0]       c0tx_addr,
  output logic [15:0]             c0tx_mdata,
  input  logic                    c0rx_valid,
  input  logic [15:0]             c0rx_mdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [UMD_W-1:0]        rsp_mdata,
  output logic [N_REQ-1:0]        busy,
  output logic                    err
`ifdef CCIP_RD_ARB_STATS_EN
  , output logic [N_REQ*32-1:0]   grant_cnt,
  output logic [31:0]             stall_cnt
`endif
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = 8;

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_win;
  logic              w_any;
  logic [N_REQ-1:0]  w_gnt;
  logic [N_REQ-1:0]  w_ok;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_dec;
  logic [N_REQ-1:0]  w_lane_err;
  logic [ID_W-1:0]   w_tag;
  logic              w_tag_bad;
  logic              r_c0tx_valid;
  logic [ADDR_W-1:0] r_c0tx_addr;
  logic [15:0]       r_c0tx_mdata;
  logic [UMD_W-1:0]  r_rsp_mdata;
  logic              r_err;

  assign w_elig    = req_valid & w_ok & {N_REQ{~c0tx_almfull}};
  assign w_tag     = c0rx_mdata[15:16-ID_W];
  assign w_tag_bad = c0rx_valid & ({1'b0, w_tag} >= (ID_W+1)'(N_REQ));

  // Round-robin pick: first eligible index at or after r_ptr, wrapping.
  always_comb begin : arb
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_any && w_elig[idx]) begin
        w_any = 1'b1;
        w_win = PTR_W'(idx);
      end
    end
    w_gnt = w_any ? (N_REQ'(1) << w_win) : '0;
  end

  assign req_ready = w_gnt;

  // Per-requester lanes.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign w_dec[i] = c0rx_valid & (w_tag == ID_W'(i));
    ccip_c0_rd_arbiter_lane #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_lane (
      .afu_clk   (afu_clk),
      .afu_rst_n (afu_rst_n),
      .i_inc     (w_gnt[i]),
      .i_dec     (w_dec[i]),
      .o_ok      (w_ok[i]),
      .o_busy    (busy[i]),
      .o_rsp     (rsp_valid[i]),
      .o_err     (w_lane_err[i])
`ifdef CCIP_RD_ARB_STATS_EN
      , .o_gnt_cnt (grant_cnt[i*32 +: 32])
`endif
    );
  end

  // Pointer, registered c0 request, response mdata and sticky error.
  always_ff @(posedge afu_clk or negedge afu_rst_n) begin
    if (!afu_rst_n) begin
      r_ptr        <= '0;
      r_c0tx_valid <= 1'b0;
      r_c0tx_addr  <= '0;
      r_c0tx_mdata <= '0;
      r_rsp_mdata  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_c0tx_valid <= w_any;
      if (w_any) begin
        r_ptr        <= (w_win == PTR_W'(N_REQ-1)) ? '0 : w_win + 1'b1;
        r_c0tx_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
        r_c0tx_mdata <= {ID_W'(w_win), req_mdata[w_win*UMD_W +: UMD_W]};
      end
      r_rsp_mdata <= c0rx_valid ? c0rx_mdata[UMD_W-1:0] : '0;
      r_err       <= r_err | w_tag_bad | (|w_lane_err);
    end
  end

  assign c0tx_valid = r_c0tx_valid;
  assign c0tx_addr  = r_c0tx_addr;
  assign c0tx_mdata = r_c0tx_mdata;
  assign rsp_mdata  = r_rsp_mdata;
  assign err        = r_err;

`ifdef CCIP_RD_ARB_STATS_EN
  logic [31:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;

  // Cycles where someone wanted the channel but nobody got it.
  always_ff @(posedge afu_clk or negedge afu_rst_n) begin
    if (!afu_rst_n)                  r_stall_cnt <= '0;
    else if (|req_valid && !w_any)   r_stall_cnt <= r_stall_cnt + 32'd1;
  end
`endif
endmodule
